// File: rtl/muldiv_controller_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states, op classification.
package muldiv_controller_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_DIVU  = 2'd1,
    MD_MTHI  = 2'd2,
    MD_MTLO  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } muldiv_state_t;

  // True for ops that occupy the iterative datapath for WIDTH cycles.
  function automatic logic is_long_op(input muldiv_op_t op);
    return (op == MD_MULTU) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_controller_if.sv
// Execute/decode-side connection to the HI/LO unit; master is the pipeline, slave is the unit.
interface muldiv_controller_if #(parameter int WIDTH = 32);
  import muldiv_controller_pkg::*;

  logic             e_start;
  muldiv_op_t       e_op;
  logic [WIDTH-1:0] e_a;
  logic [WIDTH-1:0] e_b;
  logic             d_use_hilo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output e_start, e_op, e_a, e_b, d_use_hilo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  e_start, e_op, e_a, e_b, d_use_hilo,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 iteration, purely combinational: shift-add multiply step and restoring divide step.
// acc holds the partial product / remainder, work holds the multiplier / dividend-quotient.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] mul_acc,
  output logic [WIDTH-1:0] mul_work,
  output logic [WIDTH-1:0] div_acc,
  output logic [WIDTH-1:0] div_work
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_shift;
  logic           borrow;

  always_comb begin
    // Multiply: add multiplicand when the low multiplier bit is set, then shift the pair right.
    mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_acc  = mul_sum[WIDTH:1];
    mul_work = {mul_sum[0], work[WIDTH-1:1]};

    // Divide: bring in the next dividend bit, keep the difference only if it did not go negative.
    rem_shift = {acc, work[WIDTH-1]};
    borrow    = rem_shift < {1'b0, opnd};
    div_acc   = borrow ? rem_shift[WIDTH-1:0] : WIDTH'(rem_shift - {1'b0, opnd});
    div_work  = {work[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO unit beside the execute ALU: sequences MULTU/DIVU over WIDTH edges, handles MTHI/MTLO,
// owns HI/LO and raises stall while a decode-stage HI/LO user would see a stale result.
module muldiv_controller
  import muldiv_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  muldiv_controller_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, work, opnd;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             load, commit, mt_hi, mt_lo, last;
  logic [WIDTH-1:0] mul_acc, mul_work, div_acc, div_work;
  logic [WIDTH-1:0] step_acc, step_work;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .work     (work),
    .opnd     (opnd),
    .mul_acc  (mul_acc),
    .mul_work (mul_work),
    .div_acc  (div_acc),
    .div_work (div_work)
  );

  assign last      = (count == CW'(WIDTH - 1));
  assign step_acc  = (state == DIV) ? div_acc  : mul_acc;
  assign step_work = (state == DIV) ? div_work : mul_work;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.e_start) begin
          case (bus.e_op)
            MD_MULTU: begin state_nxt = MUL; load = 1'b1; end
            MD_DIVU:  begin state_nxt = DIV; load = 1'b1; end
            MD_MTHI:  mt_hi = 1'b1;
            MD_MTLO:  mt_lo = 1'b1;
            default:  ;
          endcase
        end
      end
      MUL, DIV: begin
        // New starts are dropped here; the stall keeps a correct pipeline from issuing them.
        if (last) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      work   <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (load) begin
        count <= '0;
        acc   <= '0;
        work  <= (bus.e_op == MD_DIVU) ? bus.e_a : bus.e_b;
        opnd  <= (bus.e_op == MD_DIVU) ? bus.e_b : bus.e_a;
      end else if (state != IDLE) begin
        count <= count + CW'(1);
        acc   <= step_acc;
        work  <= step_work;
      end
      if (commit) begin
        hi_q <= step_acc;
        lo_q <= step_work;
      end
      if (mt_hi) hi_q <= bus.e_a;
      if (mt_lo) lo_q <= bus.e_a;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.d_use_hilo & (bus.busy | (bus.e_start & is_long_op(bus.e_op)));

endmodule

// File: tb/tb_muldiv_controller.sv
// Bench for muldiv_controller: directed cases plus random ops, compared every cycle against an arithmetic model.
module tb_muldiv_controller;
  import muldiv_controller_pkg::*;

  localparam int WIDTH = 32;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  bit   check_en;

  muldiv_controller_if #(.WIDTH(WIDTH)) bus ();

  muldiv_controller #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted long op fixes its answer by plain arithmetic and releases it WIDTH edges later.
  int          m_remaining;
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  bit          m_done;
  logic [63:0] m_prod;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_remaining = 0;
      m_hi = 0; m_lo = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_remaining > 0) begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_hi = m_res_hi; m_lo = m_res_lo; m_done = 1;
        end
      end else if (bus.e_start) begin
        case (bus.e_op)
          MD_MULTU: begin
            m_prod = 64'(bus.e_a) * 64'(bus.e_b);
            m_res_hi = m_prod[63:32]; m_res_lo = m_prod[31:0];
            m_remaining = WIDTH;
          end
          MD_DIVU: begin
            if (bus.e_b == 0) begin
              m_res_lo = 32'hFFFF_FFFF; m_res_hi = bus.e_a;
            end else begin
              m_res_lo = bus.e_a / bus.e_b; m_res_hi = bus.e_a % bus.e_b;
            end
            m_remaining = WIDTH;
          end
          MD_MTHI: m_hi = bus.e_a;
          default: m_lo = bus.e_a;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (check_en && !reset) begin
      chk("busy",  64'(bus.busy),  64'(m_remaining > 0));
      chk("done",  64'(bus.done),  64'(m_done));
      chk("hi",    64'(bus.hi),    64'(m_hi));
      chk("lo",    64'(bus.lo),    64'(m_lo));
      chk("stall", 64'(bus.stall),
          64'(bus.d_use_hilo & ((m_remaining > 0) |
              (bus.e_start & ((bus.e_op == MD_MULTU) | (bus.e_op == MD_DIVU))))));
    end
  end

  logic e0_stall;

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    bus.e_start = 1'b1; bus.e_op = op; bus.e_a = a; bus.e_b = b;
    @(negedge clock);
    e0_stall = bus.stall;
    @(posedge clock); #1;
    bus.e_start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output int stall_cnt);
    bit seen;
    busy_cnt = 0; stall_cnt = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.done) begin seen = 1; break; end
      if (bus.busy)  busy_cnt++;
      if (bus.stall) stall_cnt++;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  int bc, sc;

  initial begin
    n_cmp = 0; n_err = 0; check_en = 0;
    reset = 1'b1;
    bus.e_start = 1'b0; bus.e_op = MD_MULTU; bus.e_a = '0; bus.e_b = '0; bus.d_use_hilo = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.d_use_hilo = 1'b0;
    check_en = 1;

    issue(MD_MULTU, 32'd7, 32'd6);
    wait_done(bc, sc);
    chk("mul7x6_busy_cycles", 64'(bc), 64'd32);
    chk("mul7x6_hi", 64'(bus.hi), 64'h0);
    chk("mul7x6_lo", 64'(bus.lo), 64'h2A);
    @(negedge clock);
    chk("mul7x6_done_pulse", 64'(bus.done), 64'd0);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, sc);
    chk("mulmax_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("mulmax_lo", 64'(bus.lo), 64'h1);

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(bc, sc);
    chk("div100_7_lo", 64'(bus.lo), 64'd14);
    chk("div100_7_hi", 64'(bus.hi), 64'd2);

    issue(MD_DIVU, 32'h1234_5678, 32'd0);
    wait_done(bc, sc);
    chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(bus.hi), 64'h1234_5678);

    bus.d_use_hilo = 1'b1;
    issue(MD_MULTU, 32'd3, 32'd5);
    chk("mfl_stall_e0", 64'(e0_stall), 64'd1);
    wait_done(bc, sc);
    chk("mfl_stall_cycles", 64'(sc), 64'd32);
    chk("mfl_stall_after", 64'(bus.stall), 64'd0);
    chk("mfl_lo", 64'(bus.lo), 64'd15);

    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_stall", 64'(e0_stall), 64'd0);
    @(negedge clock);
    chk("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mthi_lo_kept", 64'(bus.lo), 64'd15);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    bus.d_use_hilo = 1'b0;

    issue(MD_MULTU, 32'd9, 32'd9);
    repeat (5) @(posedge clock);
    issue(MD_MULTU, 32'd100, 32'd100);
    wait_done(bc, sc);
    chk("ignored_start_lo", 64'(bus.lo), 64'd81);
    chk("ignored_start_hi", 64'(bus.hi), 64'd0);

    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    issue(MD_MULTU, 32'd2, 32'd2);
    wait_done(bc, sc);
    chk("after_abort_lo", 64'(bus.lo), 64'd4);

    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      bus.e_start    = ($urandom_range(0, 3) == 0);
      bus.e_op       = muldiv_op_t'($urandom_range(0, 3));
      bus.e_a        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      bus.e_b        = ($urandom_range(0, 7) == 0) ? 32'd0 :
                       (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      bus.d_use_hilo = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    bus.e_start = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
